// File: rtl/mlaccel_spi_slave.sv
// mlaccel_spi_slave: SPI mode-0 target front end for the accelerator command path.
//
// The spi_csb, spi_clk and spi_mosi pins are oversampled in the clock domain.
// MOSI is deserialised into bytes for the command FSM, and the first byte of each
// transaction is flagged with din_start. Reply bytes are serialised onto MISO,
// MSB first. During the command phase, MISO reads 0x00.
//
// Optional feature: define MLACCEL_SPI_GLITCHFILT_EN to insert a 3-sample majority
// filter after the spi_clk synchroniser. The filter rejects 1-cycle SCK glitches
// and adds 1 cycle to every SCK-derived latency.
//
// Ports:
//   clock, reset           system clock; synchronous active-high reset
//   active                 synchronised chip select is asserted (CSB low)
//   spi_csb/clk/mosi/miso  SPI pins (mode 0)
//   din_valid/start/data   received byte strobe, first-byte flag, byte
//   dout_valid/ready/data  reply byte handshake (ready pulses when tx loads)
module mlaccel_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic       active,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       din_valid,
    output logic       din_start,
    output logic [7:0] din_data,
    input  logic       dout_valid,
    output logic       dout_ready,
    input  logic [7:0] dout_data
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, mosi_sync_q, flush_q;
    logic       csb_s, sck_s, mosi_s, sck_f;
    logic       sck_prev_q, csb_prev_q;
    logic       sck_rise, sck_fall, csb_fall, armed;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, din_data_q, din_data_d;
    logic       lockout_q, lockout_d, first_q, first_d, got_byte_q, got_byte_d;
    logic       byte_done_q, byte_done_d, byte_first_q, byte_first_d;
    logic       din_valid_q, din_valid_d, din_start_q, din_start_d;
    logic       dout_ready_q, dout_ready_d, miso_q, miso_d;

    assign csb_s  = csb_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef MLACCEL_SPI_GLITCHFILT_EN
    logic [1:0] sck_hist_q;
    // Majority of the current sample and the two before it: a 1-cycle pulse never wins.
    assign sck_f = (sck_s & sck_hist_q[0]) | (sck_s & sck_hist_q[1]) |
                   (sck_hist_q[0] & sck_hist_q[1]);
    always_ff @(posedge clock) begin
        if (reset) sck_hist_q <= 2'b00;
        else       sck_hist_q <= {sck_hist_q[0], sck_s};
    end
`else
    assign sck_f = sck_s;
`endif

    assign sck_rise = sck_f & ~sck_prev_q;
    assign sck_fall = ~sck_f & sck_prev_q;
    assign csb_fall = csb_prev_q & ~csb_s;
    assign armed    = (state_q == StXfer) & ~csb_s;

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (csb_fall && !lockout_q) state_d = StXfer;
            StXfer:  if (csb_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        first_d      = first_q;
        got_byte_d   = got_byte_q;
        byte_first_d = byte_first_q;
        byte_done_d  = 1'b0;
        dout_ready_d = 1'b0;
        din_valid_d  = byte_done_q;
        din_start_d  = byte_done_q & byte_first_q;
        din_data_d   = byte_done_q ? rx_q : din_data_q;
        miso_d       = armed & tx_q[7];
        // The lockout stays set until the flushed synchroniser shows CSB high.
        // A transaction that was in flight at reset is therefore never joined.
        lockout_d    = lockout_q & ~(flush_q[SYNC_STAGES-1] & csb_s);

        if (state_q == StIdle) begin
            bit_cnt_d  = 3'd0;
            got_byte_d = 1'b0;
            tx_d       = 8'h00;
            first_d    = csb_fall & ~lockout_q;
        end else if (armed) begin
            if (sck_rise) begin
                rx_d      = {rx_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d  = 1'b1;
                    byte_first_d = first_q;
                    first_d      = 1'b0;
                    got_byte_d   = 1'b1;
                end
            end
            if (sck_fall) begin
                if (bit_cnt_q != 3'd0) begin
                    tx_d = {tx_q[6:0], 1'b0};
                end else if (got_byte_q) begin
                    // Byte boundary: load the reply, or 0x00 without consuming upstream.
                    tx_d         = dout_valid ? dout_data : 8'h00;
                    dout_ready_d = dout_valid;
                end
            end
        end else begin
            // CSB is rising this cycle. Any partial byte is dropped.
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            csb_sync_q   <= '1;
            sck_sync_q   <= '0;
            mosi_sync_q  <= '0;
            flush_q      <= '0;
            sck_prev_q   <= 1'b0;
            csb_prev_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            lockout_q    <= 1'b1;
            first_q      <= 1'b0;
            got_byte_q   <= 1'b0;
            byte_done_q  <= 1'b0;
            byte_first_q <= 1'b0;
            din_valid_q  <= 1'b0;
            din_start_q  <= 1'b0;
            din_data_q   <= 8'h00;
            dout_ready_q <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            csb_sync_q   <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
            sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            flush_q      <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q   <= sck_f;
            csb_prev_q   <= csb_s;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            lockout_q    <= lockout_d;
            first_q      <= first_d;
            got_byte_q   <= got_byte_d;
            byte_done_q  <= byte_done_d;
            byte_first_q <= byte_first_d;
            din_valid_q  <= din_valid_d;
            din_start_q  <= din_start_d;
            din_data_q   <= din_data_d;
            dout_ready_q <= dout_ready_d;
            miso_q       <= miso_d;
        end
    end

    assign active     = ~csb_s;
    assign spi_miso   = miso_q;
    assign din_valid  = din_valid_q;
    assign din_start  = din_start_q;
    assign din_data   = din_data_q;
    assign dout_ready = dout_ready_q;

endmodule

// File: tb/tb_mlaccel_spi_slave.sv
module tb_mlaccel_spi_slave;

    localparam int HALF = 8;  // SCK half period in clock cycles

    logic       clock = 1'b0;
    logic       reset;
    logic       active;
    logic       spi_csb, spi_clk, spi_mosi, spi_miso;
    logic       din_valid, din_start;
    logic [7:0] din_data;
    logic       dout_valid, dout_ready;
    logic [7:0] dout_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream reply source and receive monitor (sampled on the falling clock edge)
    logic [7:0] rep_tbl [64];
    int         rep_idx = 0;
    int         rep_hi  = 0;
    logic [7:0] ev_data  [64];
    logic       ev_start [64];
    int         ev_cnt  = 0;
    int         rdy_cnt = 0;
    int         viol    = 0;
    logic       dv_prev = 1'b0;
    logic       dr_prev = 1'b0;

    assign dout_valid = (rep_idx < rep_hi);
    assign dout_data  = rep_tbl[rep_idx & 63];

    mlaccel_spi_slave #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .active     (active),
        .spi_csb    (spi_csb),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .din_valid  (din_valid),
        .din_start  (din_start),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (din_valid) begin
            ev_data[ev_cnt & 63]  <= din_data;
            ev_start[ev_cnt & 63] <= din_start;
            ev_cnt                <= ev_cnt + 1;
        end
        if (dout_ready) begin
            rdy_cnt <= rdy_cnt + 1;
            rep_idx <= rep_idx + 1;
        end
        if ((din_valid && dv_prev) || (dout_ready && dr_prev)) viol <= viol + 1;
        dv_prev <= din_valid;
        dr_prev <= dout_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Shift nbits of b MSB first. With glitch set, a 1-cycle SCK pulse is inserted
    // in each low phase. The returned m holds the MISO bits sampled on the rising edges.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit glitch,
                            output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            if (glitch) begin
                tick(3);
                spi_clk = 1'b1;
                tick(1);
                spi_clk = 1'b0;
                tick(4);
            end else begin
                tick(HALF);
            end
            spi_clk = 1'b1;
            m = {m[6:0], spi_miso};
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_csb = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_csb = 1'b1;
        tick(12);
    endtask

    logic [7:0] m;
    int         base_ev, base_rdy;

    initial begin
        reset = 1'b1; spi_csb = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        tick(5);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_din_valid", {31'd0, din_valid}, 32'd0);
        chk("rst_din_start", {31'd0, din_start}, 32'd0);
        chk("rst_din_data", {24'd0, din_data}, 32'd0);
        chk("rst_dout_ready", {31'd0, dout_ready}, 32'd0);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        reset = 1'b0;
        tick(10);

        // T1: 0x20 then 0x00, a single reply 0xFF
        rep_tbl[rep_idx & 63] = 8'hFF; rep_hi = rep_idx + 1;
        base_ev = ev_cnt; base_rdy = rdy_cnt;
        cs_low();
        chk("t1_active", {31'd0, active}, 32'd1);
        spi_bits(8'h20, 8, 1'b0, m); chk("t1_miso0", {24'd0, m}, 32'h00);
        spi_bits(8'h00, 8, 1'b0, m); chk("t1_miso1", {24'd0, m}, 32'hFF);
        cs_high();
        chk("t1_ev_cnt", ev_cnt - base_ev, 32'd2);
        chk("t1_ev0_data", {24'd0, ev_data[base_ev & 63]}, 32'h20);
        chk("t1_ev0_start", {31'd0, ev_start[base_ev & 63]}, 32'd1);
        chk("t1_ev1_data", {24'd0, ev_data[(base_ev + 1) & 63]}, 32'h00);
        chk("t1_ev1_start", {31'd0, ev_start[(base_ev + 1) & 63]}, 32'd0);
        chk("t1_ready_cnt", rdy_cnt - base_rdy, 32'd1);
        chk("t1_idle_active", {31'd0, active}, 32'd0);
        chk("t1_idle_miso", {31'd0, spi_miso}, 32'd0);

        // T2: 0x22 plus 4 bytes, replies 11 22 33 44
        rep_tbl[rep_idx & 63]       = 8'h11;
        rep_tbl[(rep_idx + 1) & 63] = 8'h22;
        rep_tbl[(rep_idx + 2) & 63] = 8'h33;
        rep_tbl[(rep_idx + 3) & 63] = 8'h44;
        rep_hi = rep_idx + 4;
        base_ev = ev_cnt; base_rdy = rdy_cnt;
        cs_low();
        spi_bits(8'h22, 8, 1'b0, m); chk("t2_miso0", {24'd0, m}, 32'h00);
        spi_bits(8'hA1, 8, 1'b0, m); chk("t2_miso1", {24'd0, m}, 32'h11);
        spi_bits(8'hB2, 8, 1'b0, m); chk("t2_miso2", {24'd0, m}, 32'h22);
        spi_bits(8'hC3, 8, 1'b0, m); chk("t2_miso3", {24'd0, m}, 32'h33);
        spi_bits(8'hD4, 8, 1'b0, m); chk("t2_miso4", {24'd0, m}, 32'h44);
        cs_high();
        chk("t2_ready_cnt", rdy_cnt - base_rdy, 32'd4);
        chk("t2_ev_cnt", ev_cnt - base_ev, 32'd5);
        chk("t2_ev0_data", {24'd0, ev_data[base_ev & 63]}, 32'h22);
        chk("t2_ev0_start", {31'd0, ev_start[base_ev & 63]}, 32'd1);
        chk("t2_ev4_data", {24'd0, ev_data[(base_ev + 4) & 63]}, 32'hD4);
        chk("t2_ev4_start", {31'd0, ev_start[(base_ev + 4) & 63]}, 32'd0);

        // T3: dout_valid held low for three bytes
        rep_hi = rep_idx;
        base_ev = ev_cnt; base_rdy = rdy_cnt;
        cs_low();
        spi_bits(8'h30, 8, 1'b0, m); chk("t3_miso0", {24'd0, m}, 32'h00);
        spi_bits(8'h31, 8, 1'b0, m); chk("t3_miso1", {24'd0, m}, 32'h00);
        spi_bits(8'h32, 8, 1'b0, m); chk("t3_miso2", {24'd0, m}, 32'h00);
        cs_high();
        chk("t3_ready_cnt", rdy_cnt - base_rdy, 32'd0);
        chk("t3_ev_cnt", ev_cnt - base_ev, 32'd3);
        chk("t3_ev2_data", {24'd0, ev_data[(base_ev + 2) & 63]}, 32'h32);

        // T4: CSB raised after 5 bits, then a fresh 0x25 transaction
        base_ev = ev_cnt;
        cs_low();
        spi_bits(8'hFF, 5, 1'b0, m);
        cs_high();
        chk("t4_partial_ev", ev_cnt - base_ev, 32'd0);
        cs_low();
        spi_bits(8'h25, 8, 1'b0, m);
        cs_high();
        chk("t4_ev_cnt", ev_cnt - base_ev, 32'd1);
        chk("t4_data", {24'd0, ev_data[base_ev & 63]}, 32'h25);
        chk("t4_start", {31'd0, ev_start[base_ev & 63]}, 32'd1);

        // T5: reset after 3 bits, 13 more edges with CSB low, then 0xA5
        base_ev = ev_cnt;
        cs_low();
        spi_bits(8'hFF, 3, 1'b0, m);
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        spi_bits(8'hFF, 8, 1'b0, m);
        spi_bits(8'hFF, 5, 1'b0, m);
        cs_high();
        chk("t5_lockout_ev", ev_cnt - base_ev, 32'd0);
        cs_low();
        spi_bits(8'hA5, 8, 1'b0, m);
        cs_high();
        chk("t5_ev_cnt", ev_cnt - base_ev, 32'd1);
        chk("t5_data", {24'd0, ev_data[base_ev & 63]}, 32'hA5);
        chk("t5_start", {31'd0, ev_start[base_ev & 63]}, 32'd1);

        // T6: 1-cycle SCK glitch inside every bit of 0x5A
        base_ev = ev_cnt;
        cs_low();
        spi_bits(8'h5A, 8, 1'b1, m);
        cs_high();
`ifdef MLACCEL_SPI_GLITCHFILT_EN
        chk("t6_ev_cnt", ev_cnt - base_ev, 32'd1);
        chk("t6_data", {24'd0, ev_data[base_ev & 63]}, 32'h5A);
        chk("t6_start", {31'd0, ev_start[base_ev & 63]}, 32'd1);
`else
        // Each bit is captured twice: 0,0,1,1,0,0,1,1 then 1,1,0,0,1,1,0,0
        chk("t6_ev_cnt", ev_cnt - base_ev, 32'd2);
        chk("t6_data0", {24'd0, ev_data[base_ev & 63]}, 32'h33);
        chk("t6_start0", {31'd0, ev_start[base_ev & 63]}, 32'd1);
        chk("t6_data1", {24'd0, ev_data[(base_ev + 1) & 63]}, 32'hCC);
        chk("t6_start1", {31'd0, ev_start[(base_ev + 1) & 63]}, 32'd0);
`endif

        chk("strobe_width", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mlaccel_spi_slave.md
# mlaccel_spi_slave

SPI mode-0 target front end for the accelerator command path. Oversamples the external `spi_csb`/`spi_clk`/`spi_mosi` pins in the system clock domain and deserialises MOSI into a byte stream that feeds the command state machine in `mlaccel_top`. Serialises reply bytes from that state machine onto MISO. The first byte of every transaction is flagged as the command byte.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each pin synchroniser. Legal values are 2 or 3.

Ports:
- `clock`  in  1  system clock; all logic is single-clock.
- `reset`  in  1  synchronous, active-high reset.
- `active`  out  1  synchronised chip-select asserted (CSB low).
- `spi_csb`  in  1  chip select, active low, asynchronous to `clock`.
- `spi_clk`  in  1  SPI clock, asynchronous to `clock`, idles low.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `din_valid`  out  1  one-cycle strobe: `din_data` holds a complete received byte.
- `din_start`  out  1  qualifies `din_valid`: the byte is the first byte of the transaction.
- `din_data`  out  8  received byte; held until the next `din_valid`.
- `dout_valid`  in  1  `dout_data` holds the next reply byte.
- `dout_ready`  out  1  one-cycle strobe: the reply byte was loaded into the TX shifter.
- `dout_data`  in  8  reply byte.

## Operation
Input conditioning:
- Each pin passes through a `SYNC_STAGES`-deep synchroniser.
- Edge detection compares the synchronised `spi_clk` with a one-cycle-delayed copy.
- `active` equals the synchronised, inverted `spi_csb`.

Receive:
- Each rising edge of `spi_clk` while `active` shifts the synchronised MOSI into `rx[7:0]` and increments `bit_cnt` (3 bits).
- When `bit_cnt` wraps from 7 to 0, the block issues a `din_valid` pulse on the next cycle with `din_data` = the assembled byte.
- `din_start` is 1 on that pulse only if it is the first byte since CSB fell. A `first` flag is set on CSB falling and cleared after that byte.

Transmit:
- `tx[7:0]` drives `spi_miso = tx[7]` while `active`. `spi_miso` is 0 while inactive.
- `tx` clears to 0x00 when CSB falls, so command-phase MISO reads 0x00.
- On a falling edge of `spi_clk` with `bit_cnt == 0`, when at least one byte has been received this transaction, the block loads the next reply:
  - if `dout_valid` is 1: `tx <= dout_data` and `dout_ready` pulses for one cycle;
  - otherwise: `tx <= 8'h00` and there is no `dout_ready` pulse.
- On any other falling edge, `tx <= {tx[6:0], 1'b0}`.
- A falling edge with `bit_cnt == 0` before the first byte has completed is ignored.

Boundary conditions:
- CSB rising mid-byte: `bit_cnt` clears to 0 and the partial byte is discarded; no `din_valid`.
- `spi_clk` edges while inactive: ignored.
- `dout_valid` deasserted at a load point: the reply for that byte is 0x00 and the upstream byte is not consumed.
- Back-to-back transactions: the CSB high time must be at least 2 synchroniser delays. Each new transaction re-arms `first`.
- Reset mid-transaction: state clears, and the block ignores the bus until the synchronised CSB has been observed high. No `din_valid` fires on the remainder of that transaction.

State:
- Two-state FSM: IDLE (CSB high or post-reset lockout) and XFER (CSB low, armed).
- IDLE → XFER on synchronised CSB falling, provided `lockout` is clear.
- XFER → IDLE on synchronised CSB rising or on reset.

## Timing
- Reset values:
  - outputs: `active`=0, `din_valid`=0, `din_start`=0, `din_data`=0, `dout_ready`=0, `spi_miso`=0;
  - internal: `bit_cnt`=0, `tx`=0, `lockout`=1.
- Rising edge at pin to MOSI bit captured: `SYNC_STAGES`+1 cycles.
- 8th rising edge at pin to `din_valid`: `SYNC_STAGES`+2 cycles (add 1 cycle with the filter).
- Falling edge at pin to new `spi_miso`: `SYNC_STAGES`+2 cycles.
- `dout_ready` pulses in the same cycle `tx` loads.
- Upstream has until the falling edge after byte N completes to present reply byte N+1. With the minimum SCK timing this is at least 3 cycles after the `din_valid` of byte N.
- SCK high and low times must each be at least `SYNC_STAGES`+4 `clock` cycles (+1 with the filter).
- `din_valid` and `dout_ready` never stay high for two consecutive cycles.

## Configuration
- `MLACCEL_SPI_GLITCHFILT_EN` defined:
  - a 3-sample majority filter follows the `spi_clk` synchroniser;
  - edges are detected on the filtered signal;
  - pulses of one `clock` cycle are rejected;
  - all SCK-derived latencies increase by 1 cycle.
- Undefined: no filter, and the latencies are exactly as listed in Timing.
- MOSI and CSB paths are identical in both builds.

## Test plan
- CSB low, send 0x20 then 0x00, `dout_valid`=1 with `dout_data`=0xFF after the first byte → `din_valid`+`din_start` with 0x20; then `din_valid` with 0x00 and `din_start`=0; MISO reads 0x00, 0xFF; exactly one `dout_ready`.
- Send 0x22 plus 4 bytes, upstream supplies 0x11, 0x22, 0x33, 0x44 via the valid/ready handshake → MISO stream reads 0x00, 0x11, 0x22, 0x33, 0x44; four `dout_ready` pulses.
- `dout_valid` held 0 through a 3-byte transfer → MISO all 0x00; `dout_ready` never asserted.
- CSB raised after 5 SCK edges, then a new transaction with 0x25 → no `din_valid` for the partial byte; next byte is 0x25 with `din_start`=1.
- `reset` pulsed after 3 bits of a byte, CSB stays low for 13 more edges → no `din_valid`; after CSB high then low, byte 0xA5 is received with `din_start`=1.
- With `MLACCEL_SPI_GLITCHFILT_EN`, a 1-cycle SCK glitch injected inside each bit of 0x5A → 0x5A received intact. Without the macro, the same stimulus produces a misaligned byte.
